pll_reset_sequencer: RTL and testbench

- Sits directly after a PLL wrapper and supervises it.
- Synchronises the PLL lock indication and pulses the PLL reset on start-up or lock timeout.
- Requires lock to be stable before releasing a configurable number of downstream domain resets in a staggered order.
- Tears all domain resets down on lock loss and counts relock events, so HDMI/video pipelines come out of reset only on a clean clock.

---
 rtl/pll_seq_pkg.sv | 38 +++
 rtl/sync_bit.sv | 34 +++
 rtl/pll_reset_sequencer.sv | 176 +++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer.
//
// Contents:
//   state_t        - sequencer FSM states. The encoding is visible on state_o,
//                    so it must stay fixed: 0..4 = PLL_RESET .. RUN.
//   seq_cnt_width  - width of the shared cycle counter. The counter must hold
//                    the longest span it is ever compared against.

package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RESET = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } state_t;

    // Counter width: $clog2 of the largest span, plus one bit of headroom.
    function automatic int seq_cnt_width(input int timeout_span,
                                         input int stable_span,
                                         input int reset_span,
                                         input int stagger_span);
        int m;
        m = timeout_span;
        if (stable_span > m) begin
            m = stable_span;
        end
        if (reset_span > m) begin
            m = reset_span;
        end
        if (stagger_span > m) begin
            m = stagger_span;
        end
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single, slowly changing status bit that is
// asynchronous to clk (PLL lock, transceiver ready, and similar).
//
// Ports:
//   clk    - destination clock
//   rst_n  - asynchronous active-low reset; the whole chain clears to 0
//   d      - asynchronous input bit
//   q      - d delayed by STAGES clk edges
//
// Only single-bit level signals belong here. Multi-bit buses need a
// handshake or a gray-coded crossing instead.

module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], d};
        end
    end

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL supervisor and staggered domain reset release.
//
// Behaviour:
//   - Pulses pll_rst at start-up and again after every lock timeout.
//   - Waits until the synchronised lock indication has been stable.
//   - Releases the domain resets one by one, bit 0 first.
//   - Drops every domain reset at once if lock is lost.
//
// Ports:
//   clk              - free-running reference clock (not a PLL output)
//   rst_n            - asynchronous active-low reset
//   pll_locked_async - raw PLL LOCK pin, asynchronous to clk
//   clear_err        - synchronous pulse; clears timeout_err and relock_count
//   pll_rst          - active-high PLL reset
//   domain_rst_n     - active-low domain resets, released in ascending order
//   all_ready        - high only while in RUN
//   timeout_err      - sticky flag, set on any lock timeout
//   relock_count     - saturating count of lock losses after release began
//   state_o          - FSM state, for debug/LEDs

module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int NUM_DOMAINS         = 2,
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int STAGGER_CYCLES      = 8,
    parameter int CNT_W               = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pll_locked_async,
    input  logic                   clear_err,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_rst_n,
    output logic                   all_ready,
    output logic                   timeout_err,
    output logic [CNT_W-1:0]       relock_count,
    output logic [2:0]             state_o
);

    localparam int STAGGER_SPAN = STAGGER_CYCLES * (NUM_DOMAINS - 1) + 1;
    localparam int CW = seq_cnt_width(LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES,
                                      PLL_RST_CYCLES, STAGGER_SPAN);

    logic                   locked_s;
    state_t                 state_reg, state_next;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic [NUM_DOMAINS-1:0] dom_reg, dom_next;
    logic                   pll_rst_reg, all_ready_reg;
    logic                   terr_reg, terr_next;
    logic [CNT_W-1:0]       relock_reg, relock_next;
    logic [NUM_DOMAINS-1:0] rel_hit;
    logic                   lock_lost;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked_async),
        .q     (locked_s)
    );

    // rel_hit[i] is high in the RELEASE cycle whose edge releases domain i.
    generate
        for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_rel
            localparam logic [CW-1:0] REL_AT = CW'(gi * STAGGER_CYCLES);
            assign rel_hit[gi] = (cnt_reg == REL_AT);
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg + 1'b1;
        dom_next    = '0;
        terr_next   = terr_reg;
        relock_next = relock_reg;
        lock_lost   = 1'b0;

        case (state_reg)
            PLL_RESET: begin
                if (cnt_reg == CW'(PLL_RST_CYCLES - 1)) begin
                    state_next = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                // A lock seen in the final cycle still wins over the timeout.
                if (locked_s) begin
                    state_next = STABILIZE;
                end else if (cnt_reg == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
                    state_next = PLL_RESET;
                    terr_next  = 1'b1;
                end
            end
            STABILIZE: begin
                if (!locked_s) begin
                    state_next = WAIT_LOCK;
                end else if (cnt_reg == CW'(LOCK_STABLE_CYCLES - 1)) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (!locked_s) begin
                    lock_lost = 1'b1;
                end else begin
                    dom_next = dom_reg | rel_hit;
                    if (rel_hit[NUM_DOMAINS-1]) begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                // Hold the counter so that it never wraps in a long RUN.
                cnt_next = cnt_reg;
                if (!locked_s) begin
                    lock_lost = 1'b1;
                end else begin
                    dom_next = '1;
                end
            end
            default: begin
                state_next = PLL_RESET;
            end
        endcase

        if (lock_lost) begin
            state_next = WAIT_LOCK;
            dom_next   = '0;
            if (relock_reg != '1) begin
                relock_next = relock_reg + 1'b1;
            end
        end

        if (state_next != state_reg) begin
            cnt_next = '0;
        end

        if (clear_err) begin
            terr_next   = 1'b0;
            relock_next = '0;
        end
    end

    // pll_rst and all_ready are registered from state_next. Decoding them from
    // state_reg could glitch while several state bits change at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= PLL_RESET;
            cnt_reg       <= '0;
            dom_reg       <= '0;
            pll_rst_reg   <= 1'b1;
            all_ready_reg <= 1'b0;
            terr_reg      <= 1'b0;
            relock_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            dom_reg       <= dom_next;
            pll_rst_reg   <= (state_next == PLL_RESET);
            all_ready_reg <= (state_next == RUN);
            terr_reg      <= terr_next;
            relock_reg    <= relock_next;
        end
    end

    assign pll_rst      = pll_rst_reg;
    assign domain_rst_n = dom_reg;
    assign all_ready    = all_ready_reg;
    assign timeout_err  = terr_reg;
    assign relock_count = relock_reg;
    assign state_o      = state_reg;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer.
//
// The reference model works in terms of "phase" and "cycles spent in phase".
// It derives domain_rst_n arithmetically from the time spent in RELEASE.
// Directed scenarios add literal cycle-exact expectations. A randomized lock
// pattern then exercises the device against the model.

module tb_pll_reset_sequencer;

    localparam int N    = 3;
    localparam int SYNC = 2;
    localparam int RSTC = 4;
    localparam int TO   = 64;
    localparam int STAB = 16;
    localparam int STAG = 3;
    localparam int CNTW = 8;
    localparam int RC_MAX = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            pll_locked_async = 1'b0;
    logic            clear_err = 1'b0;
    logic            pll_rst;
    logic [N-1:0]    domain_rst_n;
    logic            all_ready;
    logic            timeout_err;
    logic [CNTW-1:0] relock_count;
    logic [2:0]      state_o;

    int n_checks = 0;
    int n_fail   = 0;

    pll_reset_sequencer #(
        .NUM_DOMAINS         (N),
        .SYNC_STAGES         (SYNC),
        .PLL_RST_CYCLES      (RSTC),
        .LOCK_TIMEOUT_CYCLES (TO),
        .LOCK_STABLE_CYCLES  (STAB),
        .STAGGER_CYCLES      (STAG),
        .CNT_W               (CNTW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pll_locked_async (pll_locked_async),
        .clear_err        (clear_err),
        .pll_rst          (pll_rst),
        .domain_rst_n     (domain_rst_n),
        .all_ready        (all_ready),
        .timeout_err      (timeout_err),
        .relock_count     (relock_count),
        .state_o          (state_o)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int ph;        // 0 reset pulse, 1 wait lock, 2 stabilize, 3 release, 4 run
    int age;       // cycles already spent in ph
    int rc;
    bit terr;
    bit lhist[$];  // lock samples still in flight through the synchroniser
    int cyc;       // clk edges since reset release

    task automatic model_reset();
        ph   = 0;
        age  = 0;
        rc   = 0;
        terr = 1'b0;
        cyc  = 0;
        lhist.delete();
        for (int i = 0; i < SYNC; i++) begin
            lhist.push_back(1'b0);
        end
    endtask

    task automatic model_step();
        bit ls;
        bit loss;
        int nph;
        ls = lhist[0];
        void'(lhist.pop_front());
        lhist.push_back(pll_locked_async);
        nph  = ph;
        loss = 1'b0;
        case (ph)
            0: if (age + 1 >= RSTC) nph = 1;
            1: begin
                if (ls) nph = 2;
                else if (age + 1 >= TO) begin
                    nph  = 0;
                    terr = 1'b1;
                end
            end
            2: begin
                if (!ls) nph = 1;
                else if (age + 1 >= STAB) nph = 3;
            end
            3: begin
                if (!ls) loss = 1'b1;
                else if (age >= (N - 1) * STAG) nph = 4;
            end
            default: if (!ls) loss = 1'b1;
        endcase
        if (loss) begin
            nph = 1;
            if (rc < RC_MAX) rc = rc + 1;
        end
        if (clear_err) begin
            terr = 1'b0;
            rc   = 0;
        end
        age = (nph != ph) ? 0 : age + 1;
        ph  = nph;
        cyc = cyc + 1;
    endtask

    function automatic logic [N-1:0] exp_dom();
        logic [N-1:0] d;
        d = '0;
        if (ph == 4) begin
            d = '1;
        end else if (ph == 3) begin
            for (int i = 0; i < N; i++) begin
                d[i] = (age > i * STAG);
            end
        end
        return d;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t cyc=%0d: got %0h expected %0h", nm, $time, cyc, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            check("model_pll_rst", 32'(pll_rst), 32'(ph == 0));
            check("model_state", 32'(state_o), 32'(ph));
            check("model_domain_rst_n", 32'(domain_rst_n), 32'(exp_dom()));
            check("model_all_ready", 32'(all_ready), 32'(ph == 4));
            check("model_timeout_err", 32'(timeout_err), 32'(terr));
            check("model_relock_count", 32'(relock_count), 32'(rc));
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        pll_locked_async = 1'b0;
        clear_err = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int hi;
        int lo;
        // Scenario 1: power-up, lock asserted at cycle 10 and held.
        do_reset();
        check("reset_pll_rst", 32'(pll_rst), 32'd1);
        check("reset_domains", 32'(domain_rst_n), 32'd0);
        wait_to(3);  check("pwr_pll_rst_c4", 32'(pll_rst), 32'd1);
        wait_to(4);  check("pwr_pll_rst_c5", 32'(pll_rst), 32'd0);
                     check("pwr_state_c5", 32'(state_o), 32'd1);
        wait_to(9);  pll_locked_async = 1'b1;
        wait_to(11); check("pwr_state_c12", 32'(state_o), 32'd1);
        wait_to(12); check("pwr_state_c13", 32'(state_o), 32'd2);
        wait_to(27); check("pwr_state_c28", 32'(state_o), 32'd2);
        wait_to(28); check("pwr_state_c29", 32'(state_o), 32'd3);
                     check("pwr_dom_c29", 32'(domain_rst_n), 32'b000);
        wait_to(29); check("pwr_dom_c30", 32'(domain_rst_n), 32'b001);
        wait_to(32); check("pwr_dom_c33", 32'(domain_rst_n), 32'b011);
                     check("pwr_ready_c33", 32'(all_ready), 32'd0);
        wait_to(35); check("pwr_dom_c36", 32'(domain_rst_n), 32'b111);
                     check("pwr_ready_c36", 32'(all_ready), 32'd1);
                     check("pwr_state_c36", 32'(state_o), 32'd4);
                     check("pwr_relock_c36", 32'(relock_count), 32'd0);
        $display("scenario power_up done at cyc %0d", cyc);

        // Scenario 2: one-cycle lock drop in RUN.
        wait_to(40); pll_locked_async = 1'b0;
        wait_to(41); pll_locked_async = 1'b1;
        wait_to(42); check("drop_dom_before", 32'(domain_rst_n), 32'b111);
        wait_to(43); check("drop_dom_after", 32'(domain_rst_n), 32'b000);
                     check("drop_ready_after", 32'(all_ready), 32'd0);
                     check("drop_relock", 32'(relock_count), 32'd1);
                     check("drop_state", 32'(state_o), 32'd1);
        wait_to(75); check("drop_rerun_state", 32'(state_o), 32'd4);
                     check("drop_rerun_relock", 32'(relock_count), 32'd1);
        $display("scenario run_drop done at cyc %0d", cyc);

        // Scenario 3: one-cycle glitch at the 8th STABILIZE cycle.
        do_reset();
        wait_to(9);  pll_locked_async = 1'b1;
        wait_to(17); pll_locked_async = 1'b0;
        wait_to(18); pll_locked_async = 1'b1;
        wait_to(19); check("glitch_state_c20", 32'(state_o), 32'd2);
        wait_to(20); check("glitch_state_c21", 32'(state_o), 32'd1);
        wait_to(36); check("glitch_state_c37", 32'(state_o), 32'd2);
        wait_to(37); check("glitch_state_c38", 32'(state_o), 32'd3);
                     check("glitch_relock", 32'(relock_count), 32'd0);
        $display("scenario stabilize_glitch done at cyc %0d", cyc);

        // Scenario 4: lock never asserts.
        do_reset();
        wait_to(67);  check("nolock_pll_rst_c68", 32'(pll_rst), 32'd0);
                      check("nolock_terr_c68", 32'(timeout_err), 32'd0);
        wait_to(68);  check("nolock_pll_rst_c69", 32'(pll_rst), 32'd1);
                      check("nolock_terr_c69", 32'(timeout_err), 32'd1);
                      check("nolock_state_c69", 32'(state_o), 32'd0);
        wait_to(72);  check("nolock_pll_rst_c73", 32'(pll_rst), 32'd0);
        wait_to(136); check("nolock_pll_rst_c137", 32'(pll_rst), 32'd1);
                      check("nolock_dom", 32'(domain_rst_n), 32'd0);
        $display("scenario no_lock done at cyc %0d", cyc);

        // Scenario 5: 300 lock drops, each landing in RUN, then clear_err.
        for (int k = 0; k < 300; k++) begin
            pll_locked_async = 1'b1;
            repeat (29) @(negedge clk);
            pll_locked_async = 1'b0;
            @(negedge clk);
        end
        pll_locked_async = 1'b1;
        repeat (4) @(negedge clk);
        check("sat_relock", 32'(relock_count), 32'd255);
        check("sat_terr", 32'(timeout_err), 32'd1);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("clr_relock", 32'(relock_count), 32'd0);
        check("clr_terr", 32'(timeout_err), 32'd0);
        $display("scenario saturate_clear done at cyc %0d", cyc);

        // Scenario 6: randomized lock activity and clear_err pulses.
        for (int k = 0; k < 60; k++) begin
            hi = $urandom_range(1, 50);
            lo = ($urandom_range(0, 5) == 0) ? $urandom_range(60, 90) : $urandom_range(1, 8);
            pll_locked_async = 1'b1;
            for (int j = 0; j < hi; j++) begin
                clear_err = ($urandom_range(0, 15) == 0);
                @(negedge clk);
            end
            pll_locked_async = 1'b0;
            for (int j = 0; j < lo; j++) begin
                clear_err = ($urandom_range(0, 15) == 0);
                @(negedge clk);
            end
        end
        clear_err = 1'b0;
        $display("scenario random done at cyc %0d", cyc);

        // Scenario 7: asynchronous reset mid-RELEASE with domains at 011.
        do_reset();
        wait_to(9);  pll_locked_async = 1'b1;
        wait_to(33); check("arst_dom_before", 32'(domain_rst_n), 32'b011);
        #2 rst_n = 1'b0;
        #1;
        check("arst_dom", 32'(domain_rst_n), 32'b000);
        check("arst_pll_rst", 32'(pll_rst), 32'd1);
        check("arst_state", 32'(state_o), 32'd0);
        check("arst_ready", 32'(all_ready), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        $display("scenario async_reset done at cyc %0d", cyc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
